// File: rtl/ssd_display_scheduler.sv
// ssd_display_scheduler
//
// Purpose:
//   Shares a 4-digit seven-segment display between one base source and two
//   overlay requesters. Overlays are time-boxed to HOLD_TICKS refresh
//   periods. Leading zeros can be blanked. The block also generates the
//   digit-refresh strobe for the downstream multiplexing driver.
//
// Parameters:
//   REFRESH_DIV  clocks per refresh_tick pulse (>= 2)
//   HOLD_TICKS   refresh ticks an overlay stays on screen (>= 1)
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous, active-low
//   base_value     live BCD value shown when no overlay is active
//   req1, value1   low-priority overlay request (level) and value
//   req2, value2   high-priority overlay request (level) and value
//   blank_lz       replace leading zeros with 4'hF
//   ack1, ack2     one-clock accept pulses
//   grant          one-hot active overlay ([0]=overlay 1, [1]=overlay 2)
//   refresh_tick   one-clock pulse every REFRESH_DIV clocks
//   thousands_o .. ones_o  registered displayed digits
//
// State table:
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_BASE   | base_value on display; accepts req2, then req1
//   ST_SHOW1  | overlay 1 on display; only req2 (preemption) is accepted
//   ST_SHOW2  | overlay 2 on display; all requests ignored until timeout

module ssd_display_scheduler #(
    parameter int REFRESH_DIV = 100000,
    parameter int HOLD_TICKS  = 2000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] base_value,
    input  logic        req1,
    input  logic [15:0] value1,
    input  logic        req2,
    input  logic [15:0] value2,
    input  logic        blank_lz,
    output logic        ack1,
    output logic        ack2,
    output logic [1:0]  grant,
    output logic        refresh_tick,
    output logic [3:0]  thousands_o,
    output logic [3:0]  hundreds_o,
    output logic [3:0]  tens_o,
    output logic [3:0]  ones_o
);

    localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(REFRESH_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        ST_BASE  = 2'd0,
        ST_SHOW1 = 2'd1,
        ST_SHOW2 = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [DW-1:0]   div_cnt;
    logic [HW-1:0]   hold_cnt;
    logic [15:0]     overlay;
    logic            accept1;
    logic            accept2;
    logic            hold_done;
    logic [1:0]      grant_next;
    logic [15:0]     sel_value;
    logic [15:0]     shown;

    // Free-running refresh divider; the tick is registered so it lands on
    // the cycle right after the counter wraps.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt      <= '0;
            refresh_tick <= 1'b0;
        end else begin
            if (div_cnt == DIV_LAST)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 1'b1;
            refresh_tick <= (div_cnt == DIV_LAST);
        end
    end

    assign hold_done = refresh_tick && (hold_cnt == HOLD_LAST);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= ST_BASE;
        else
            state <= state_next;
    end

    // Next-state logic. Preemption in ST_SHOW1 wins over a coincident
    // timeout so overlay 2 is never lost.
    always_comb begin
        state_next = state;
        accept1    = 1'b0;
        accept2    = 1'b0;
        case (state)
            ST_BASE: begin
                if (req2) begin
                    accept2    = 1'b1;
                    state_next = ST_SHOW2;
                end else if (req1) begin
                    accept1    = 1'b1;
                    state_next = ST_SHOW1;
                end
            end
            ST_SHOW1: begin
                if (req2) begin
                    accept2    = 1'b1;
                    state_next = ST_SHOW2;
                end else if (hold_done) begin
                    state_next = ST_BASE;
                end
            end
            ST_SHOW2: begin
                if (hold_done)
                    state_next = ST_BASE;
            end
            default: state_next = ST_BASE;
        endcase
    end

    // Output logic: digit source follows the next state so the display
    // changes on the same edge as grant. On the accept edge the overlay
    // register is not loaded yet, so the request value is used directly.
    always_comb begin
        grant_next = 2'b00;
        sel_value  = base_value;
        case (state_next)
            ST_SHOW1: begin
                grant_next = 2'b01;
                sel_value  = accept1 ? value1 : overlay;
            end
            ST_SHOW2: begin
                grant_next = 2'b10;
                sel_value  = accept2 ? value2 : overlay;
            end
            default: begin
                grant_next = 2'b00;
                sel_value  = base_value;
            end
        endcase

        shown = sel_value;
        if (blank_lz) begin
            if (sel_value[15:12] == 4'h0)
                shown[15:12] = 4'hF;
            if (sel_value[15:8] == 8'h00)
                shown[11:8] = 4'hF;
            if (sel_value[15:4] == 12'h000)
                shown[7:4] = 4'hF;
        end
    end

    // Registered outputs, overlay capture and hold counter. A tick that
    // coincides with an accept is dropped because the counter is cleared.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_cnt    <= '0;
            overlay     <= 16'h0000;
            ack1        <= 1'b0;
            ack2        <= 1'b0;
            grant       <= 2'b00;
            thousands_o <= 4'h0;
            hundreds_o  <= 4'h0;
            tens_o      <= 4'h0;
            ones_o      <= 4'h0;
        end else begin
            if (accept1 || accept2 || (state_next == ST_BASE))
                hold_cnt <= '0;
            else if (refresh_tick)
                hold_cnt <= hold_cnt + 1'b1;

            if (accept2)
                overlay <= value2;
            else if (accept1)
                overlay <= value1;

            ack1        <= accept1;
            ack2        <= accept2;
            grant       <= grant_next;
            thousands_o <= shown[15:12];
            hundreds_o  <= shown[11:8];
            tens_o      <= shown[7:4];
            ones_o      <= shown[3:0];
        end
    end

endmodule

// File: tb/tb_ssd_display_scheduler.sv
// Directed bench for ssd_display_scheduler with REFRESH_DIV=4, HOLD_TICKS=3.
// cyc counts rising edges since reset release; inputs change and outputs
// are sampled on the falling edge.

module tb_ssd_display_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] base_value = 16'h1234;
    logic        req1 = 1'b0;
    logic [15:0] value1 = 16'h0000;
    logic        req2 = 1'b0;
    logic [15:0] value2 = 16'h0000;
    logic        blank_lz = 1'b0;
    logic        ack1;
    logic        ack2;
    logic [1:0]  grant;
    logic        refresh_tick;
    logic [3:0]  thousands_o;
    logic [3:0]  hundreds_o;
    logic [3:0]  tens_o;
    logic [3:0]  ones_o;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    ssd_display_scheduler #(
        .REFRESH_DIV(4),
        .HOLD_TICKS (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .base_value  (base_value),
        .req1        (req1),
        .value1      (value1),
        .req2        (req2),
        .value2      (value2),
        .blank_lz    (blank_lz),
        .ack1        (ack1),
        .ack2        (ack2),
        .grant       (grant),
        .refresh_tick(refresh_tick),
        .thousands_o (thousands_o),
        .hundreds_o  (hundreds_o),
        .tens_o      (tens_o),
        .ones_o      (ones_o)
    );

    always #5 clock = ~clock;

    always @(posedge clock or negedge reset) begin
        if (!reset)
            cyc <= 0;
        else
            cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] digits();
        return {16'h0000, thousands_o, hundreds_o, tens_o, ones_o};
    endfunction

    task automatic go(input int n);
        int guard = 0;
        while (cyc < n && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (cyc != n)
            check_eq("go_bound", 32'(cyc), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and idle
        repeat (2) @(negedge clock);
        check_eq("rst_digits", digits(), 32'h0000);
        check_eq("rst_grant", 32'(grant), 32'h0);
        check_eq("rst_ack", 32'({ack1, ack2}), 32'h0);
        check_eq("rst_tick", 32'(refresh_tick), 32'h0);
        reset = 1'b1;
        #1;
        check_eq("pre_edge_digits", digits(), 32'h0000);
        go(1);
        check_eq("base_digits", digits(), 32'h1234);
        check_eq("idle_grant", 32'(grant), 32'h0);
        for (int i = 1; i <= 8; i++) begin
            go(i);
            check_eq("tick_phase", 32'(refresh_tick), 32'((i % 4) == 0));
        end

        // Simple overlay; accept edge 9 coincides with a tick (not counted)
        req1 = 1'b1;
        value1 = 16'h0042;
        go(9);
        check_eq("ov1_ack1", 32'(ack1), 32'h1);
        check_eq("ov1_ack2", 32'(ack2), 32'h0);
        check_eq("ov1_grant", 32'(grant), 32'h1);
        check_eq("ov1_digits", digits(), 32'h0042);
        req1 = 1'b0;
        go(10);
        check_eq("ov1_ack_drop", 32'(ack1), 32'h0);
        check_eq("ov1_grant_hold", 32'(grant), 32'h1);
        go(20);
        check_eq("ov1_before_exit", 32'(grant), 32'h1);
        check_eq("ov1_digits_late", digits(), 32'h0042);
        go(21);
        check_eq("ov1_exit_grant", 32'(grant), 32'h0);
        check_eq("ov1_exit_digits", digits(), 32'h1234);

        // Both requests: overlay 2 wins, req1 stays pending
        req1 = 1'b1;
        req2 = 1'b1;
        value1 = 16'h1111;
        value2 = 16'h2222;
        go(22);
        check_eq("prio_ack2", 32'(ack2), 32'h1);
        check_eq("prio_ack1", 32'(ack1), 32'h0);
        check_eq("prio_grant", 32'(grant), 32'h2);
        check_eq("prio_digits", digits(), 32'h2222);
        req2 = 1'b0;
        for (int i = 23; i <= 32; i++) begin
            go(i);
            check_eq("pend_no_ack1", 32'(ack1), 32'h0);
        end
        check_eq("ov2_before_exit", 32'(grant), 32'h2);
        go(33);
        check_eq("ov2_exit_grant", 32'(grant), 32'h0);
        check_eq("ov2_exit_ack1", 32'(ack1), 32'h0);
        check_eq("ov2_exit_digits", digits(), 32'h1234);
        go(34);
        check_eq("pend_ack1", 32'(ack1), 32'h1);
        check_eq("pend_grant", 32'(grant), 32'h1);
        check_eq("pend_digits", digits(), 32'h1111);
        req1 = 1'b0;

        // Preemption mid-SHOW1 after one counted tick
        go(38);
        check_eq("pre_grant01", 32'(grant), 32'h1);
        req2 = 1'b1;
        value2 = 16'h0987;
        go(39);
        check_eq("pre_grant10", 32'(grant), 32'h2);
        check_eq("pre_ack2", 32'(ack2), 32'h1);
        check_eq("pre_digits", digits(), 32'h0987);
        req2 = 1'b0;
        go(45);
        check_eq("pre_restart_mid", 32'(grant), 32'h2);
        go(48);
        check_eq("pre_restart_late", 32'(grant), 32'h2);
        go(49);
        check_eq("pre_exit_grant", 32'(grant), 32'h0);
        check_eq("pre_exit_digits", digits(), 32'h1234);

        // Leading-zero blanking
        blank_lz = 1'b1;
        base_value = 16'h0007;
        go(50);
        check_eq("blank_0007", digits(), 32'hFFF7);
        base_value = 16'h0000;
        go(51);
        check_eq("blank_0000", digits(), 32'hFFF0);
        base_value = 16'h0105;
        go(52);
        check_eq("blank_0105", digits(), 32'hF105);
        base_value = 16'h0A0C;
        go(53);
        check_eq("blank_0a0c", digits(), 32'hFA0C);
        base_value = 16'h0105;
        go(54);
        check_eq("blank_hold", digits(), 32'hF105);
        blank_lz = 1'b0;
        #1;
        check_eq("unblank_pre_edge", digits(), 32'hF105);
        go(55);
        check_eq("unblank_0105", digits(), 32'h0105);

        // Reset in the middle of an overlay 2
        base_value = 16'h1234;
        req2 = 1'b1;
        value2 = 16'h5678;
        go(56);
        check_eq("rmid_grant", 32'(grant), 32'h2);
        check_eq("rmid_digits", digits(), 32'h5678);
        req2 = 1'b0;
        go(57);
        #2;
        reset = 1'b0;
        #1;
        check_eq("rmid_async_grant", 32'(grant), 32'h0);
        check_eq("rmid_async_digits", digits(), 32'h0000);
        check_eq("rmid_async_ack", 32'({ack1, ack2}), 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        go(1);
        check_eq("rpost_grant", 32'(grant), 32'h0);
        check_eq("rpost_digits", digits(), 32'h1234);
        check_eq("rpost_ack", 32'({ack1, ack2}), 32'h0);
        go(3);
        check_eq("rpost_tick3", 32'(refresh_tick), 32'h0);
        go(4);
        check_eq("rpost_tick4", 32'(refresh_tick), 32'h1);
        go(8);
        check_eq("rpost_grant_late", 32'(grant), 32'h0);
        check_eq("rpost_digits_late", digits(), 32'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
